// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes, mux/ALU codes.
// No logic; constants and one helper only.
// Not applicable (no handshake).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_ADDR    = 4'd2,
        ST_MEM_RD  = 4'd3,
        ST_MEM_WR  = 4'd4,
        ST_WB_MEM  = 4'd5,
        ST_EXEC_R  = 4'd6,
        ST_EXEC_I  = 4'd7,
        ST_WB_ALU  = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JUMP    = 4'd10
    } state_e;

    // Opcode field values recognised in DECODE
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation codes (zero-extended to the output width at the top)
    localparam logic [1:0] ALUOP_ORI   = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;
    localparam logic [1:0] ALUOP_FUNCT = 2'b11;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALUB_RT      = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    // States that wait on the memory handshake and are covered by the wait timer
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory in the current wait state; flags when MAX_WAIT is reached.
// Count updates on the clock edge; expired_o is a pure decode of the count.
// No handshake; the controller decides when to clear or advance.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority so that every entry into a wait state starts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM (fetch/decode/execute/memory/writeback) with memory wait timeout.
// Controls are a same-cycle decode of the state register (plus zero_i, op_i, mem_ready_i where needed).
// Stalls in FETCH/MEM_RD/MEM_WR until mem_ready_i; gives up after MAX_WAIT idle cycles.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W  = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         op_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic [1:0]         pc_src_o,
    output logic               ir_write_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               iord_o,
    output logic               reg_write_o,
    output logic               reg_dst_o,
    output logic               mem_to_reg_o,
    output logic               ext_op_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               retire_o,
    output logic               illegal_o,
    output logic               timeout_o
);

    state_e     state_q;
    state_e     state_d;
    logic [5:0] op_q;
    logic [5:0] op_d;
    logic       in_wait;
    logic       expired;
    logic       timed_out;
    logic       tmr_clr;
    logic       tmr_inc;
    logic [1:0] alu_op;

    // A wait state times out only when memory is still not ready; ready wins on the limit cycle
    assign in_wait   = is_wait_state(state_q);
    assign timed_out = in_wait && !mem_ready_i && expired;
    // Clearing whenever the state is left (or outside wait states) guarantees a zero count on entry
    assign tmr_clr   = !in_wait || mem_ready_i || timed_out;
    assign tmr_inc   = in_wait && !mem_ready_i && !timed_out;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (tmr_clr),
        .inc_i     (tmr_inc),
        .expired_o (expired)
    );

    // Next-state selection; later states key off the opcode captured in DECODE
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            ST_FETCH: begin
                if (mem_ready_i)    state_d = ST_DECODE;
                else if (timed_out) state_d = ST_FETCH;
            end
            ST_DECODE: begin
                op_d = op_i;
                case (op_i)
                    OP_RTYPE:     state_d = ST_EXEC_R;
                    OP_ORI:       state_d = ST_EXEC_I;
                    OP_LW, OP_SW: state_d = ST_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_ADDR:   state_d = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (mem_ready_i)    state_d = ST_WB_MEM;
                else if (timed_out) state_d = ST_FETCH;
            end
            ST_MEM_WR: begin
                if (mem_ready_i || timed_out) state_d = ST_FETCH;
            end
            ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
            ST_WB_MEM, ST_WB_ALU, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    // State and captured-opcode registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Control decode; everything is forced low while reset is held so nothing half-completes
    always_comb begin
        pc_write_o   = 1'b0;
        pc_src_o     = PC_SRC_ALU;
        ir_write_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        ext_op_o     = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = ALUB_RT;
        alu_op       = ALUOP_ORI;
        retire_o     = 1'b0;
        illegal_o    = 1'b0;
        timeout_o    = 1'b0;
        if (!rst_i) begin
            timeout_o = timed_out;
            unique case (state_q)
                ST_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = ALUB_FOUR;
                    alu_op      = ALUOP_ADD;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                ST_DECODE: begin
                    alu_src_b_o = ALUB_IMM_SH2;
                    alu_op      = ALUOP_ADD;
                    ext_op_o    = 1'b1;
                    illegal_o   = !(op_i inside {OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J});
                end
                ST_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = ALUB_IMM;
                    ext_op_o    = 1'b1;
                    alu_op      = ALUOP_ADD;
                end
                ST_MEM_RD: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_write_o = 1'b1;
                    iord_o      = 1'b1;
                    retire_o    = mem_ready_i;
                end
                ST_WB_MEM: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                    retire_o     = 1'b1;
                end
                ST_EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = ALUB_RT;
                    alu_op      = ALUOP_FUNCT;
                end
                ST_EXEC_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = ALUB_IMM;
                    alu_op      = ALUOP_ORI;
                end
                ST_WB_ALU: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = (op_q == OP_RTYPE);
                    retire_o    = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = ALUB_RT;
                    alu_op      = ALUOP_SUB;
                    pc_src_o    = PC_SRC_ALUOUT;
                    pc_write_o  = zero_i;
                    retire_o    = 1'b1;
                end
                ST_JUMP: begin
                    pc_src_o   = PC_SRC_JUMP;
                    pc_write_o = 1'b1;
                    retire_o   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign alu_op_o = ALUOP_W'(alu_op);

endmodule
